// File: rtl/opll_bus_pkg.sv
//------------------------------------------------------------------------------
// Module   : opll_bus_pkg
// Purpose  : Shared types and timing constants for the OPLL CPU-bus write
//            sequencer: FSM state encoding, YM2413 post-write wait times and
//            a small helper used to size the wait counter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package opll_bus_pkg;

    // Sequencer states; one pair is replayed as an address cycle followed by
    // a data cycle, each with setup / strobe / hold / wait phases.
    typedef enum logic [3:0] {
        STARTUP  = 4'd0,
        IDLE     = 4'd1,
        A_SETUP  = 4'd2,
        A_STROBE = 4'd3,
        A_HOLD   = 4'd4,
        A_WAIT   = 4'd5,
        D_SETUP  = 4'd6,
        D_STROBE = 4'd7,
        D_HOLD   = 4'd8,
        D_WAIT   = 4'd9
    } opll_state_t;

    // YM2413 master-clock waits after an address write and a data write.
    localparam int OPLL_ADDR_WAIT     = 12;
    localparam int OPLL_DATA_WAIT     = 84;
    localparam int OPLL_STROBE_CYCLES = 4;
    localparam int OPLL_STARTUP_WAIT  = 1024;

    // Largest of four wait lengths; sizes the shared wait counter.
    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/opll_write_fifo.sv
//------------------------------------------------------------------------------
// Module   : opll_write_fifo
// Purpose  : Synchronous FIFO buffering {addr, data} write pairs.
// Ports    : clk, reset        - clock, synchronous active-high reset
//            push, push_data   - write strobe / entry (ignored when full)
//            pop,  pop_data    - read strobe / head entry (show-ahead)
//            full, empty, level- occupancy status, all derived from a register
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module opll_write_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_lvl_w = c_ptr_w + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_lvl_w-1:0] r_level;
    logic               w_push;
    logic               w_pop;

    assign full     = (r_level == c_lvl_w'(DEPTH));
    assign empty    = (r_level == '0);
    assign level    = r_level;
    assign pop_data = r_mem[r_rd_ptr];

    // Full blocks a push even when a pop happens on the same edge.
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_level <= r_level + 1'b1;
            else if (!w_push && w_pop) r_level <= r_level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= push_data;
    end

endmodule

`default_nettype wire

// File: rtl/opll_write_sequencer.sv
//------------------------------------------------------------------------------
// Module   : opll_write_sequencer
// Purpose  : Buffers OPLL (addr, data) register writes and replays each as an
//            address bus cycle then a data bus cycle on the YM2413 CPU pins,
//            honouring the post-write wait times and a power-up delay.
// Ports    : clk, reset               - clock, synchronous active-high reset
//            in_valid/in_ready        - write-pair stream handshake
//            in_addr, in_data         - register address / value
//            cs_n, wr_n, a0, dout     - registered chip bus outputs
//            busy                     - pending or in-flight write
//            fifo_level               - buffered pair count
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module opll_write_sequencer
    import opll_bus_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int STROBE_CYCLES = OPLL_STROBE_CYCLES,
    parameter int ADDR_WAIT     = OPLL_ADDR_WAIT,
    parameter int DATA_WAIT     = OPLL_DATA_WAIT,
    parameter int STARTUP_WAIT  = OPLL_STARTUP_WAIT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [7:0]                    in_addr,
    input  logic [7:0]                    in_data,
    output logic                          cs_n,
    output logic                          wr_n,
    output logic                          a0,
    output logic [7:0]                    dout,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int c_cnt_w = $clog2(max4(STARTUP_WAIT, DATA_WAIT, ADDR_WAIT, STROBE_CYCLES) + 1);

    // Counter load values: a state lasting N cycles is entered with N-1 so
    // the counter hits 0 in its last cycle.
    localparam logic [c_cnt_w-1:0] c_strobe_load  = c_cnt_w'(STROBE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_addr_load    = c_cnt_w'((ADDR_WAIT > 0) ? ADDR_WAIT - 1 : 0);
    localparam logic [c_cnt_w-1:0] c_data_load    = c_cnt_w'((DATA_WAIT > 0) ? DATA_WAIT - 1 : 0);
    localparam logic [c_cnt_w-1:0] c_startup_last = c_cnt_w'((STARTUP_WAIT > 0) ? STARTUP_WAIT - 1 : 0);

    opll_state_t        r_state;
    opll_state_t        w_state_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_next;
    logic               w_pop;
    logic               w_strobe_next;
    logic               w_full;
    logic               w_empty;
    logic [15:0]        w_fifo_q;
    logic               r_cs_n;
    logic               r_wr_n;
    logic               r_a0;
    logic [7:0]         r_dout;
    logic [7:0]         r_data;

    opll_write_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (in_valid && in_ready),
        .push_data ({in_addr, in_data}),
        .pop       (w_pop),
        .pop_data  (w_fifo_q),
        .full      (w_full),
        .empty     (w_empty),
        .level     (fifo_level)
    );

    assign in_ready = !w_full;
    assign busy     = !w_empty || ((r_state != IDLE) && (r_state != STARTUP));
    assign cs_n     = r_cs_n;
    assign wr_n     = r_wr_n;
    assign a0       = r_a0;
    assign dout     = r_dout;

    // Next state. Reset clears the counter, so STARTUP counts elapsed cycles
    // upwards; every other timed state counts down from its load value.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_pop        = 1'b0;
        case (r_state)
            STARTUP: begin
                if (r_cnt >= c_startup_last) begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = A_SETUP;
                end
            end
            A_SETUP: begin
                w_state_next = A_STROBE;
                w_cnt_next   = c_strobe_load;
            end
            A_STROBE: begin
                if (r_cnt == '0) w_state_next = A_HOLD;
                else             w_cnt_next   = r_cnt - 1'b1;
            end
            A_HOLD: begin
                if (ADDR_WAIT == 0) begin
                    w_state_next = D_SETUP;
                end else begin
                    w_state_next = A_WAIT;
                    w_cnt_next   = c_addr_load;
                end
            end
            A_WAIT: begin
                if (r_cnt == '0) w_state_next = D_SETUP;
                else             w_cnt_next   = r_cnt - 1'b1;
            end
            D_SETUP: begin
                w_state_next = D_STROBE;
                w_cnt_next   = c_strobe_load;
            end
            D_STROBE: begin
                if (r_cnt == '0) w_state_next = D_HOLD;
                else             w_cnt_next   = r_cnt - 1'b1;
            end
            D_HOLD: begin
                if (DATA_WAIT == 0) begin
                    w_state_next = IDLE;
                end else begin
                    w_state_next = D_WAIT;
                    w_cnt_next   = c_data_load;
                end
            end
            D_WAIT: begin
                if (r_cnt == '0) w_state_next = IDLE;
                else             w_cnt_next   = r_cnt - 1'b1;
            end
            default: begin
                w_state_next = STARTUP;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign w_strobe_next = (w_state_next == A_STROBE) || (w_state_next == D_STROBE);

    // Bus outputs are decoded from the next state and registered, so they are
    // glitch-free Moore outputs of the state register. a0/dout only change on
    // entry to a SETUP state, where the strobe is already high.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= STARTUP;
            r_cnt   <= '0;
            r_cs_n  <= 1'b1;
            r_wr_n  <= 1'b1;
            r_a0    <= 1'b0;
            r_dout  <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_cs_n  <= !w_strobe_next;
            r_wr_n  <= !w_strobe_next;
            if (w_pop) begin
                r_a0   <= 1'b0;
                r_dout <= w_fifo_q[15:8];
                r_data <= w_fifo_q[7:0];
            end else if (w_state_next == D_SETUP) begin
                r_a0   <= 1'b1;
                r_dout <= r_data;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_opll_write_sequencer.sv
//------------------------------------------------------------------------------
// Module   : tb_opll_write_sequencer
// Purpose  : Self-checking bench for opll_write_sequencer. A bus monitor turns
//            strobe pulses into (start cycle, length, a0, value) records; a
//            timing model predicts the same records from push times.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_opll_write_sequencer;

    localparam int S     = 4;
    localparam int AW    = 12;
    localparam int DW    = 84;
    localparam int SW    = 1024;
    localparam int DEPTH = 4;
    localparam int ZSW   = 8;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, in_valid, in_ready, cs_n, wr_n, a0, busy;
    logic [7:0] in_addr, in_data, dout;
    logic [2:0] fifo_level;

    logic       z_reset, z_valid, z_ready, z_cs_n, z_wr_n, z_a0, z_busy;
    logic [7:0] z_addr, z_data, z_dout;
    logic [2:0] z_level;

    opll_write_sequencer #(
        .FIFO_DEPTH(DEPTH), .STROBE_CYCLES(S), .ADDR_WAIT(AW),
        .DATA_WAIT(DW), .STARTUP_WAIT(SW)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data), .cs_n(cs_n), .wr_n(wr_n),
        .a0(a0), .dout(dout), .busy(busy), .fifo_level(fifo_level)
    );

    opll_write_sequencer #(
        .FIFO_DEPTH(DEPTH), .STROBE_CYCLES(S), .ADDR_WAIT(0),
        .DATA_WAIT(0), .STARTUP_WAIT(ZSW)
    ) dut_zero (
        .clk(clk), .reset(z_reset), .in_valid(z_valid), .in_ready(z_ready),
        .in_addr(z_addr), .in_data(z_data), .cs_n(z_cs_n), .wr_n(z_wr_n),
        .a0(z_a0), .dout(z_dout), .busy(z_busy), .fifo_level(z_level)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;
    int rst_edge = 0;
    int last_idle = 0;

    typedef struct { int start; int len; logic a0; logic [7:0] val; } wr_t;
    typedef struct { int at; logic [7:0] addr; logic [7:0] data; } push_t;

    wr_t   obs[$];
    wr_t   exp_q[$];
    push_t pushes[$];

    // Bus monitor: each low strobe pulse becomes one record.
    bit         in_strb = 1'b0;
    wr_t        cur;
    logic       prev_a0;
    logic [7:0] prev_dout;
    int         setup_err = 0, stab_err = 0, pair_err = 0;

    always @(negedge clk) begin
        if (cs_n !== wr_n) pair_err = pair_err + 1;
        if (cs_n === 1'b0) begin
            if (!in_strb) begin
                in_strb   = 1'b1;
                cur.start = cyc;
                cur.len   = 0;
                cur.a0    = a0;
                cur.val   = dout;
                if (prev_a0 !== a0 || prev_dout !== dout) setup_err = setup_err + 1;
            end
            cur.len = cur.len + 1;
            if (a0 !== cur.a0 || dout !== cur.val) stab_err = stab_err + 1;
        end else if (in_strb) begin
            obs.push_back(cur);
            in_strb = 1'b0;
        end
        prev_a0   = a0;
        prev_dout = dout;
    end

    // Timing model: the sequencer is free from edge f (idle after it); a pair
    // pushed at edge p is popped at max(p, f)+1, its address strobe starts one
    // cycle later, the data strobe S+1+AW+1 after that, and the sequencer is
    // idle again 2(S+1)+AW+DW+2 cycles after the pop.
    task automatic model_writes(input int idle_from);
        int  f;
        int  x;
        wr_t w;
        f = idle_from;
        exp_q.delete();
        foreach (pushes[i]) begin
            x = ((pushes[i].at > f) ? pushes[i].at : f) + 1;
            w.start = x + 1;           w.len = S; w.a0 = 1'b0; w.val = pushes[i].addr;
            exp_q.push_back(w);
            w.start = x + 1 + S + 1 + AW + 1; w.a0 = 1'b1; w.val = pushes[i].data;
            exp_q.push_back(w);
            f = x + 2 * (S + 1) + AW + DW + 2;
        end
        last_idle = f;
    endtask

    // Presents a pair until accepted; returns the accepting edge.
    task automatic push_pair(input logic [7:0] a, input logic [7:0] d, output int at_edge);
        logic  r;
        push_t p;
        in_valid = 1'b1; in_addr = a; in_data = d; at_edge = -1;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk); r = in_ready;
            @(posedge clk); #1;
            if (r) begin at_edge = cyc; break; end
        end
        in_valid = 1'b0;
        if (at_edge < 0) begin
            n_vec++; n_err++;
            $display("FAIL push_timeout addr=%02h never accepted", a);
        end else begin
            p.at = at_edge; p.addr = a; p.data = d;
            pushes.push_back(p);
        end
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        rst_edge = cyc;
        @(negedge clk); #1;
        obs.delete(); pushes.delete();
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        int bad;
        do_reset();
        @(negedge clk);
        n_vec++; if (cs_n !== 1'b1) begin n_err++; $display("FAIL rst_cs_n got %b want 1", cs_n); end
        n_vec++; if (wr_n !== 1'b1) begin n_err++; $display("FAIL rst_wr_n got %b want 1", wr_n); end
        n_vec++; if (a0 !== 1'b0) begin n_err++; $display("FAIL rst_a0 got %b want 0", a0); end
        n_vec++; if (dout !== 8'h00) begin n_err++; $display("FAIL rst_dout got %02h want 00", dout); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
        n_vec++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL rst_level got %0d want 0", fifo_level); end
        bad = 0;
        while (cyc < rst_edge + SW + 50) begin
            @(negedge clk);
            if (cs_n !== 1'b1 || wr_n !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) bad++;
        end
        n_vec++; if (bad != 0 || obs.size() != 0) begin
            n_err++; $display("FAIL idle_quiet got %0d bad cycles %0d strobes want 0", bad, obs.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single;
        int p;
        obs.delete(); pushes.delete();
        push_pair(8'h10, 8'hAC, p);
        model_writes(rst_edge + SW);
        wait_until(last_idle - 1);
        @(negedge clk);
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy_hi got %b want 1", busy); end
        @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_lo got %b want 0", busy); end
        @(posedge clk); #1;
        wait_until(last_idle + 2);
        n_vec++; if (obs.size() != exp_q.size()) begin
            n_err++; $display("FAIL single_count got %0d want %0d", obs.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            n_vec++;
            if (i >= obs.size()) begin n_err++; $display("FAIL single_wr%0d missing", i); end
            else if (obs[i] != exp_q[i]) begin n_err++;
                $display("FAIL single_wr%0d got t=%0d len=%0d a0=%b v=%02h want t=%0d len=%0d a0=%b v=%02h", i,
                    obs[i].start, obs[i].len, obs[i].a0, obs[i].val, exp_q[i].start, exp_q[i].len, exp_q[i].a0, exp_q[i].val); end
        end
        n_vec++; if (setup_err + stab_err + pair_err != 0) begin n_err++;
            $display("FAIL single_bus_rules got setup=%0d stab=%0d pair=%0d want 0", setup_err, stab_err, pair_err); end
    endtask

    task automatic test_backpressure;
        int p;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            push_pair(8'($urandom), 8'($urandom), p);
            if (i == 3) begin
                @(negedge clk);
                n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready got %b want 0", in_ready); end
                n_vec++; if (fifo_level !== 3'd4) begin n_err++; $display("FAIL bp_level got %0d want 4", fifo_level); end
                @(posedge clk); #1;
            end
        end
        n_vec++; if (p != rst_edge + SW + 2) begin n_err++;
            $display("FAIL bp_fifth_accept got %0d want %0d", p, rst_edge + SW + 2); end
        model_writes(rst_edge + SW);
        wait_until(last_idle + 2);
        n_vec++; if (obs.size() != exp_q.size()) begin
            n_err++; $display("FAIL bp_count got %0d want %0d", obs.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            n_vec++;
            if (i >= obs.size()) begin n_err++; $display("FAIL bp_wr%0d missing", i); end
            else if (obs[i] != exp_q[i]) begin n_err++;
                $display("FAIL bp_wr%0d got t=%0d len=%0d a0=%b v=%02h want t=%0d len=%0d a0=%b v=%02h", i,
                    obs[i].start, obs[i].len, obs[i].a0, obs[i].val, exp_q[i].start, exp_q[i].len, exp_q[i].a0, exp_q[i].val); end
        end
    endtask

    task automatic test_same_edge;
        int p;
        int want;
        do_reset();
        push_pair(8'($urandom), 8'($urandom), p);
        push_pair(8'($urandom), 8'($urandom), p);
        wait_until(rst_edge + SW - 1);
        @(negedge clk);
        n_vec++; if (fifo_level !== 3'd2) begin n_err++; $display("FAIL se_level_before got %0d want 2", fifo_level); end
        @(posedge clk); #1;
        push_pair(8'($urandom), 8'($urandom), p);
        n_vec++; if (p != rst_edge + SW + 1) begin n_err++;
            $display("FAIL se_accept got %0d want %0d", p, rst_edge + SW + 1); end
        @(negedge clk);
        n_vec++; if (fifo_level !== 3'd2) begin n_err++; $display("FAIL se_level_after got %0d want 2", fifo_level); end
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(80, 300)) @(posedge clk);
            #1;
            want = cyc + 1;
            push_pair(8'($urandom), 8'($urandom), p);
            n_vec++; if (p != want) begin n_err++; $display("FAIL se_rand_accept%0d got %0d want %0d", i, p, want); end
        end
        model_writes(rst_edge + SW);
        wait_until(last_idle + 2);
        n_vec++; if (obs.size() != exp_q.size()) begin
            n_err++; $display("FAIL se_count got %0d want %0d", obs.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            n_vec++;
            if (i >= obs.size()) begin n_err++; $display("FAIL se_wr%0d missing", i); end
            else if (obs[i] != exp_q[i]) begin n_err++;
                $display("FAIL se_wr%0d got t=%0d len=%0d a0=%b v=%02h want t=%0d len=%0d a0=%b v=%02h", i,
                    obs[i].start, obs[i].len, obs[i].a0, obs[i].val, exp_q[i].start, exp_q[i].len, exp_q[i].a0, exp_q[i].val); end
        end
    endtask

    task automatic test_reset_mid;
        int p;
        do_reset();
        push_pair(8'($urandom), 8'($urandom), p);
        push_pair(8'($urandom), 8'($urandom), p);
        model_writes(rst_edge + SW);
        wait_until(exp_q[1].start + 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        rst_edge = cyc;
        @(negedge clk);
        n_vec++; if (cs_n !== 1'b1 || wr_n !== 1'b1) begin n_err++;
            $display("FAIL mid_strobe got cs_n=%b wr_n=%b want 1 1", cs_n, wr_n); end
        n_vec++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL mid_level got %0d want 0", fifo_level); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy got %b want 0", busy); end
        #1;
        obs.delete(); pushes.delete();
        @(posedge clk); #1;
        wait_until(rst_edge + SW + 300);
        n_vec++; if (obs.size() != 0) begin n_err++; $display("FAIL mid_no_retry got %0d strobes want 0", obs.size()); end
        push_pair(8'($urandom), 8'($urandom), p);
        model_writes(rst_edge + SW);
        wait_until(last_idle + 2);
        n_vec++; if (obs.size() != exp_q.size()) begin
            n_err++; $display("FAIL mid_count got %0d want %0d", obs.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            n_vec++;
            if (i >= obs.size()) begin n_err++; $display("FAIL mid_wr%0d missing", i); end
            else if (obs[i] != exp_q[i]) begin n_err++;
                $display("FAIL mid_wr%0d got t=%0d len=%0d a0=%b v=%02h want t=%0d len=%0d a0=%b v=%02h", i,
                    obs[i].start, obs[i].len, obs[i].a0, obs[i].val, exp_q[i].start, exp_q[i].len, exp_q[i].a0, exp_q[i].val); end
        end
    endtask

    // Zero waits: offsets from the pop edge are setup 0, strobe 1..S, hold S+1,
    // data setup S+2, strobe S+3..2S+2, hold 2S+3, idle at 2S+4 (= 12).
    task automatic test_zero_wait;
        logic [7:0] a, d, e_dout;
        logic       e_cs, e_a0, e_busy;
        a = 8'($urandom); d = 8'($urandom);
        z_reset = 1'b1;
        @(posedge clk); #1;
        z_reset = 1'b0;
        repeat (ZSW + 4) @(posedge clk);
        #1;
        n_vec++; if (z_ready !== 1'b1) begin n_err++; $display("FAIL zw_ready got %b want 1", z_ready); end
        z_valid = 1'b1; z_addr = a; z_data = d;
        @(posedge clk); #1;
        z_valid = 1'b0;
        @(posedge clk);
        for (int off = 0; off <= 2 * S + 4; off++) begin
            @(negedge clk);
            e_cs   = !((off >= 1 && off <= S) || (off >= S + 3 && off <= 2 * S + 2));
            e_a0   = (off >= S + 2);
            e_dout = e_a0 ? d : a;
            e_busy = (off < 2 * S + 4);
            n_vec++;
            if (z_cs_n !== e_cs || z_wr_n !== e_cs || z_a0 !== e_a0 || z_busy !== e_busy ||
                (off < 2 * S + 4 && z_dout !== e_dout)) begin
                n_err++;
                $display("FAIL zw_cycle%0d got cs=%b wr=%b a0=%b d=%02h busy=%b want cs=%b a0=%b d=%02h busy=%b",
                    off, z_cs_n, z_wr_n, z_a0, z_dout, z_busy, e_cs, e_a0, e_dout, e_busy);
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0;
        z_reset = 1'b1; z_valid = 1'b0; z_addr = '0; z_data = '0;
        @(posedge clk); #1;
        test_reset();
        test_single();
        test_backpressure();
        test_same_edge();
        test_reset_mid();
        test_zero_wait();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/opll_write_sequencer.md
Name: opll_write_sequencer

Overview:
- Upstream stage of the OPLL top wrapper. Drives the chip's CPU bus pins: CS_n, WR_n, A0 and DIN.
- Accepts register writes as (address, data) pairs on a valid/ready stream and buffers them in a small FIFO.
- Replays each pair as two bus cycles: an address write, then a data write.
- Enforces the YM2413 post-write wait times: 12 master clocks after an address write, 84 after a data write. Here the master clock is clk, because the core runs fully synchronous with the phiM enable tied active.

Parameters:
- FIFO_DEPTH, 4: number of buffered (addr, data) pairs; power of two, at least 2.
- STROBE_CYCLES, 4: cycles cs_n/wr_n are held low per bus write; at least 1.
- ADDR_WAIT, 12: idle cycles after an address write before the data write.
- DATA_WAIT, 84: idle cycles after a data write before the next pair.
- STARTUP_WAIT, 1024: cycles after reset before the first bus write is issued.

Ports:
- clk  in  1  system clock, same clock as the OPLL core
- reset  in  1  synchronous, active-high
- in_valid  in  1  a write pair is presented
- in_ready  out  1  FIFO can accept a pair (not full)
- in_addr  in  8  OPLL register address
- in_data  in  8  OPLL register value
- cs_n  out  1  chip select, active low
- wr_n  out  1  write strobe, active low
- a0  out  1  0 = address cycle, 1 = data cycle
- dout  out  8  bus data
- busy  out  1  FIFO non-empty, or FSM not in IDLE/STARTUP
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy

Behaviour:
- Reset values (taking effect on the edge where reset is sampled high): cs_n=1, wr_n=1, a0=0, dout=0, busy=0, in_ready=1, fifo_level=0. FIFO is cleared, counters are zeroed, state = STARTUP.
- Reset mid-transaction aborts the transaction immediately: strobes deassert on the next edge and no partial write is retried.
- Handshake: a pair is pushed on an edge where in_valid && in_ready.
  - in_ready = !full, registered from occupancy.
  - There is no push-through when full, even if a pop occurs on the same edge.
  - Simultaneous push and pop when not full: level is unchanged and data order is preserved.
- All bus outputs are registered; outputs are Moore functions of the state.
- STARTUP: counts STARTUP_WAIT cycles, then goes to IDLE. The FIFO accepts pushes during STARTUP.
- IDLE: if the FIFO is non-empty, pop and go to A_SETUP. Otherwise stay.
- Bus cycle sequence, from the edge on which the pair is popped:
  - A_SETUP, 1 cycle: a0=0, dout=addr, cs_n=wr_n=1.
  - A_STROBE, STROBE_CYCLES cycles: cs_n=wr_n=0, a0/dout held.
  - A_HOLD, 1 cycle: cs_n=wr_n=1, a0/dout held.
  - A_WAIT, ADDR_WAIT cycles.
  - D_SETUP, 1 cycle: a0=1, dout=data.
  - D_STROBE, STROBE_CYCLES cycles.
  - D_HOLD, 1 cycle.
  - D_WAIT, DATA_WAIT cycles, then IDLE.
- One pair with defaults takes 1+4+1+12+1+4+1+84 = 108 cycles. Back-to-back pairs repeat every 109 cycles, including one IDLE cycle.
- Wait counter: a single down-counter loaded on entry to each timed state; it reaches 0 in the state's last cycle.
  - Its width is sized for max(STARTUP_WAIT, DATA_WAIT, ADDR_WAIT, STROBE_CYCLES).
  - A zero wait parameter means the state is skipped.
- During waits, a0/dout keep the last driven values. cs_n and wr_n always move together.
- Invariant: cs_n is never low while a0/dout change on the same edge.

Decomposition:
- Package opll_bus_pkg holds:
  - the state enum: STARTUP, IDLE, A_SETUP, A_STROBE, A_HOLD, A_WAIT, D_SETUP, D_STROBE, D_HOLD, D_WAIT;
  - default timing constants OPLL_ADDR_WAIT=12 and OPLL_DATA_WAIT=84.
- Sub-module opll_write_fifo: synchronous 16-bit-wide FIFO (FIFO_DEPTH entries) with push/pop, full/empty and level outputs.
- The FSM and counter live in the top of this block.

Test Plan:
- Reset, then no input: cs_n/wr_n stay 1 for all cycles; busy=0; in_ready=1; no strobe before STARTUP_WAIT expires.
- After startup, push (0x10, 0xAC):
  - dout=0x10 with a0=0 one cycle before a 4-cycle low strobe;
  - 13 cycles from strobe release to dout=0xAC, a0=1;
  - 4-cycle strobe;
  - busy drops 85 cycles after the data strobe ends.
- Push 5 pairs during STARTUP with FIFO_DEPTH=4: in_ready=0 after 4 accepted; the 5th is held by the source and accepted after the first pop; all 5 appear on the bus in order with a 109-cycle period.
- Assert reset in the middle of D_STROBE: cs_n=wr_n=1 on the next edge; fifo_level=0; no further writes occur until new pushes arrive after STARTUP.
- Push and pop on the same edge at level 2: fifo_level stays 2 and output order matches input order.
- ADDR_WAIT=0, DATA_WAIT=0: A_HOLD is followed directly by D_SETUP, and D_HOLD by IDLE; the pair completes in 12 cycles.
